bus_poll_scheduler: RTL

Round-robin scheduler that sequences periodic poll requests to up to N_BUS CAN bus channels in the MOPS-Hub. An internal period counter paces the requests. Each request selects the next enabled bus and runs a req/ack handshake with the shared bus-access datapath. Handshakes are guarded by a timeout. Sits between hub configuration (enable, mask) and the shared CAN transmit path.

---
 rtl/bus_poll_scheduler.sv | 116 +++++++++++
 1 files changed

// File: rtl/bus_poll_scheduler.sv
// bus_poll_scheduler: tick-paced round-robin poll requester for CAN bus channels with req/ack timeout.
// Ports: clk, rst (sync, active-low); enable, bus_mask, poll_ack in;
// poll_req, poll_bus_id, busy, timeout_err, err_bus_id, round_done, ack_count, to_count out.
// Optional POLL_STATS_EN builds saturating ack/timeout counters; otherwise both counts read 0.
module bus_poll_scheduler #(
  parameter int N_BUS   = 16,
  parameter int ID_W    = 5,
  parameter int PERIOD  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_BUS-1:0] bus_mask,
  input  logic             poll_ack,
  output logic             poll_req,
  output logic [ID_W-1:0]  poll_bus_id,
  output logic             busy,
  output logic             timeout_err,
  output logic [ID_W-1:0]  err_bus_id,
  output logic             round_done,
  output logic [15:0]      ack_count,
  output logic [15:0]      to_count
);
  typedef enum logic [1:0] {IDLE, ARM, REQ} state_t;
  state_t state;
  logic [7:0] tick_cnt, wait_cnt;
  logic [ID_W-1:0] last_id, sel_id, hi_id, lo_id;
  logic tick, sel_valid, hi_ok, lo_ok, hi_set, fin_ack, to_hit, fin;
  assign tick      = tick_cnt == 8'(PERIOD - 1);
  assign sel_valid = |bus_mask;
  assign fin_ack   = state == REQ && poll_ack;
  assign to_hit    = state == REQ && !poll_ack && wait_cnt == 8'(TIMEOUT - 1);
  assign fin       = fin_ack || to_hit;
  // Round-robin: lowest set bit above last_id wins, else wrap to lowest set bit at or below it.
  always_comb begin
    hi_id = '0;
    lo_id = '0;
    hi_ok = 1'b0;
    lo_ok = 1'b0;
    for (int i = N_BUS - 1; i >= 0; i--) begin
      if (bus_mask[i] && i > int'(last_id)) begin
        hi_id = ID_W'(i);
        hi_ok = 1'b1;
      end
      if (bus_mask[i] && i <= int'(last_id)) begin
        lo_id = ID_W'(i);
        lo_ok = 1'b1;
      end
    end
    sel_id = hi_ok ? hi_id : lo_id;
  end
  // A round ends when no participating bus sits above the one just served.
  always_comb begin
    hi_set = 1'b0;
    for (int i = 0; i < N_BUS; i++)
      if (bus_mask[i] && i > int'(poll_bus_id)) hi_set = 1'b1;
  end
  always_ff @(posedge clk)
    tick_cnt <= (!rst || !enable || tick) ? 8'd0 : tick_cnt + 8'd1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      poll_req    <= 1'b0;
      busy        <= 1'b0;
      poll_bus_id <= '0;
      last_id     <= ID_W'(N_BUS - 1);
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      err_bus_id  <= '0;
      round_done  <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      round_done  <= 1'b0;
      case (state)
        IDLE: if (enable) state <= ARM;
        ARM: begin
          if (!enable) state <= IDLE;
          else if (tick && sel_valid) begin
            state       <= REQ;
            poll_req    <= 1'b1;
            busy        <= 1'b1;
            poll_bus_id <= sel_id;
            wait_cnt    <= '0;
          end
        end
        REQ: begin
          if (fin) begin
            state       <= enable ? ARM : IDLE;
            poll_req    <= 1'b0;
            busy        <= 1'b0;
            last_id     <= poll_bus_id;
            round_done  <= !hi_set;
            timeout_err <= to_hit;
            if (to_hit) err_bus_id <= poll_bus_id;
          end else wait_cnt <= wait_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef POLL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_count <= '0;
      to_count  <= '0;
    end else begin
      if (fin_ack && ack_count != 16'hFFFF) ack_count <= ack_count + 16'd1;
      if (to_hit && to_count != 16'hFFFF) to_count <= to_count + 16'd1;
    end
  end
`else
  assign ack_count = '0;
  assign to_count  = '0;
`endif
endmodule
